// File: rtl/led_pattern_gen.sv
// Purpose : LED pattern generator (binary count, rotate, bounce, Gray count) stepped by a prescaler.
// Latency : runled/tick are registered; a step shows on the edge that ends the last prescaler cycle.
// Backpr. : none; enable=0 freezes prescaler and pattern, a mode change reloads the pattern at once.
//
// Ports:
//   clk     - single clock, all state on its rising edge
//   reset   - asynchronous, active-high reset
//   enable  - 1 runs prescaler and pattern, 0 freezes both (tick forced low)
//   mode    - 00 binary count, 01 rotate, 10 bounce, 11 Gray count
//   runled  - registered LED pattern, LED_WIDTH bits
//   tick    - registered one-cycle strobe, high in the cycle runled first shows a new step
module led_pattern_gen #(
  parameter int unsigned LED_WIDTH  = 10,
  parameter int unsigned DECIMATION = 20'd1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  output logic [LED_WIDTH-1:0] runled,
  output logic                 tick
);

  localparam logic [1:0] MODE_COUNT  = 2'b00;
  localparam logic [1:0] MODE_ROTATE = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_GRAY   = 2'b11;

  localparam logic [19:0]          PRESC_LAST = 20'(DECIMATION - 1);
  localparam logic [LED_WIDTH-1:0] LED_ONE    = {{(LED_WIDTH-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [19:0]          presc_q,  presc_d;
  logic [1:0]           mode_q,   mode_d;
  logic [LED_WIDTH-1:0] cnt_q,    cnt_d;     // binary count shared by modes 00 and 11
  logic [LED_WIDTH-1:0] runled_q, runled_d;
  logic                 dir_up_q, dir_up_d;  // bounce direction, 1 = toward MSB
  logic                 tick_q,   tick_d;

  // ---------------------------------------------------------------------------
  // Step qualification
  // ---------------------------------------------------------------------------
  logic mode_chg;
  logic presc_wrap;
  logic step;

  assign mode_chg   = (mode != mode_q);
  assign presc_wrap = (presc_q == PRESC_LAST);
  // A pending mode change always wins over a coinciding step.
  assign step       = enable & presc_wrap & ~mode_chg;

  // ---------------------------------------------------------------------------
  // Per-mode next patterns
  // ---------------------------------------------------------------------------
  logic [LED_WIDTH-1:0] cnt_inc;
  logic [LED_WIDTH-1:0] gray_next;
  logic [LED_WIDTH-1:0] rot_next;
  logic [LED_WIDTH-1:0] bounce_next;
  logic                 bounce_dir_next;

  assign cnt_inc   = cnt_q + LED_ONE;
  assign gray_next = cnt_inc ^ (cnt_inc >> 1);
  assign rot_next  = {runled_q[LED_WIDTH-2:0], runled_q[LED_WIDTH-1]};

  // Direction flips on the step that lands on an end bit, so each end bit
  // is shown for exactly one step before the dot heads back.
  always_comb begin
    bounce_next     = runled_q;
    bounce_dir_next = dir_up_q;
    if (dir_up_q) begin
      bounce_next = runled_q << 1;
      if (bounce_next[LED_WIDTH-1]) begin
        bounce_dir_next = 1'b0;
      end
    end else begin
      bounce_next = runled_q >> 1;
      if (bounce_next[0]) begin
        bounce_dir_next = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    mode_d   = mode;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    runled_d = runled_q;
    dir_up_d = dir_up_q;
    tick_d   = 1'b0;

    if (mode_chg) begin
      // Load the initial state of the new mode, independent of enable.
      presc_d  = '0;
      cnt_d    = '0;
      dir_up_d = 1'b1;
      if ((mode == MODE_ROTATE) || (mode == MODE_BOUNCE)) begin
        runled_d = LED_ONE;
      end else begin
        runled_d = '0;
      end
    end else if (enable) begin
      presc_d = presc_wrap ? '0 : presc_q + 20'd1;
      if (step) begin
        tick_d = 1'b1;
        unique case (mode_q)
          MODE_COUNT: begin
            cnt_d    = cnt_inc;
            runled_d = cnt_inc;
          end
          MODE_ROTATE: begin
            runled_d = rot_next;
          end
          MODE_BOUNCE: begin
            runled_d = bounce_next;
            dir_up_d = bounce_dir_next;
          end
          MODE_GRAY: begin
            cnt_d    = cnt_inc;
            runled_d = gray_next;
          end
          default: begin
            runled_d = runled_q;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      mode_q   <= MODE_COUNT;
      cnt_q    <= '0;
      runled_q <= '0;
      dir_up_q <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      runled_q <= runled_d;
      dir_up_q <= dir_up_d;
      tick_q   <= tick_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign runled = runled_q;
  assign tick   = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Purpose : self-checking bench for led_pattern_gen (LED_WIDTH=4, DECIMATION=4 and DECIMATION=1).
// Latency : expected patterns are queued ahead of stimulus and popped on each DUT tick.
// Backpr. : n/a.
module tb_led_pattern_gen;

  logic       clk;
  logic       reset, enable;
  logic [1:0] mode;
  logic [3:0] runled;
  logic       tick;

  logic       reset_b, enable_b;
  logic [1:0] mode_b;
  logic [3:0] runled_b;
  logic       tick_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] sb_q[$];
  logic [3:0] exp_led;
  logic [3:0] prev_led;
  int         cyc = 0;
  int         last_tick = 0;
  logic       have_last = 1'b0;
  logic       spacing_en = 1'b0;
  logic       rearm = 1'b0;

  led_pattern_gen #(.LED_WIDTH(4), .DECIMATION(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .runled (runled),
    .tick   (tick)
  );

  led_pattern_gen #(.LED_WIDTH(4), .DECIMATION(1)) dut_d1 (
    .clk    (clk),
    .reset  (reset_b),
    .enable (enable_b),
    .mode   (mode_b),
    .runled (runled_b),
    .tick   (tick_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: samples 2 time units after each rising edge.
  always begin
    @(posedge clk);
    #2;
    cyc++;
    if (tick === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_tick", 32'(tick), 32'd0);
      end else begin
        exp_led = sb_q.pop_front();
        chk("tick_led", 32'(runled), 32'(exp_led));
      end
      if (mode == 2'b01 || mode == 2'b10) chk("onehot", 32'($countones(runled)), 32'd1);
      if (mode == 2'b11) chk("gray_step", 32'($countones(runled ^ prev_led)), 32'd1);
      if (spacing_en && have_last) chk("tick_spacing", 32'(cyc - last_tick), 32'd4);
      last_tick = cyc;
      have_last = 1'b1;
      if (rearm) begin
        spacing_en = 1'b1;
        rearm      = 1'b0;
      end
      prev_led = runled;
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic wait_tick(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < budget);
    chk("tick_seen", 32'(tick), 32'd1);
  endtask

  // Switch mode at a negedge and check the initial state loaded on the next edge.
  task automatic change_mode(input logic [1:0] m, input logic [3:0] init);
    spacing_en = 1'b0;
    rearm      = 1'b1;
    mode       = m;
    @(negedge clk);
    chk("mode_init_led", 32'(runled), 32'(init));
    chk("mode_init_tick", 32'(tick), 32'd0);
    prev_led = init;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] bounce_seq [7];
    bounce_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    reset = 1'b1; enable = 1'b0; mode = 2'b00;
    reset_b = 1'b1; enable_b = 1'b0; mode_b = 2'b00;
    prev_led = 4'b0000;

    @(negedge clk);
    @(negedge clk);
    chk("rst_led", 32'(runled), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_led_d1", 32'(runled_b), 32'd0);

    // Binary count: first step after 4 enabled cycles, 16 steps wrap to zero.
    for (int i = 0; i < 16; i++) sb_q.push_back(4'((i + 1) % 16));
    reset      = 1'b0;
    enable     = 1'b1;
    spacing_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("cnt_pre_tick", 32'(tick), 32'd0);
    @(negedge clk);
    chk("cnt_first_tick", 32'(tick), 32'd1);
    wait_drain(80);

    // Mode change 00 -> 01 in the step cycle: no tick, 0001 loaded, next step 4 cycles on.
    repeat (3) @(negedge clk);
    sb_q.push_back(4'b0010);
    change_mode(2'b01, 4'b0001);
    repeat (3) begin
      @(negedge clk);
      chk("mc_quiet", 32'(tick), 32'd0);
    end
    @(negedge clk);
    chk("mc_tick", 32'(tick), 32'd1);

    // Rotate continues around the MSB.
    sb_q.push_back(4'b0100);
    sb_q.push_back(4'b1000);
    sb_q.push_back(4'b0001);
    wait_drain(20);

    // Gray count.
    change_mode(2'b11, 4'b0000);
    sb_q.push_back(4'b0001);
    sb_q.push_back(4'b0011);
    sb_q.push_back(4'b0010);
    sb_q.push_back(4'b0110);
    wait_drain(24);

    // Bounce.
    change_mode(2'b10, 4'b0001);
    for (int i = 0; i < 7; i++) sb_q.push_back(bounce_seq[i]);
    wait_drain(40);

    // Freeze with prescaler at 2 for 10 cycles; resume steps after 2 enabled cycles.
    spacing_en = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("frz_led", 32'(runled), 32'(4'b0010));
      chk("frz_tick", 32'(tick), 32'd0);
    end
    sb_q.push_back(4'b0100);
    enable = 1'b1;
    @(negedge clk);
    chk("frz_resume_quiet", 32'(tick), 32'd0);
    @(negedge clk);
    chk("frz_resume_tick", 32'(tick), 32'd1);

    // Asynchronous reset while tick is high.
    sb_q.push_back(4'b1000);
    wait_tick(8);
    #1 reset = 1'b1;
    #1;
    chk("arst_led", 32'(runled), 32'd0);
    chk("arst_tick", 32'(tick), 32'd0);

    // Inputs ignored during reset.
    mode = 2'b01;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hold_led", 32'(runled), 32'd0);
    chk("rst_hold_tick", 32'(tick), 32'd0);

    // Reset mid-count discards the partial prescaler count.
    mode = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    sb_q.push_back(4'b0001);
    repeat (3) begin
      @(negedge clk);
      chk("rst_partial_quiet", 32'(tick), 32'd0);
    end
    @(negedge clk);
    chk("rst_partial_tick", 32'(tick), 32'd1);

    // Release reset with a non-count mode: loads that mode's initial state.
    enable = 1'b0;
    #1 reset = 1'b1;
    mode = 2'b01;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rel_load", 32'(runled), 32'(4'b0001));
    chk("rst_rel_tick", 32'(tick), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    // DECIMATION=1: step on every enabled cycle, tick held high.
    reset_b  = 1'b0;
    enable_b = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("d1_led", 32'(runled_b), 32'(k % 16));
      chk("d1_tick", 32'(tick_b), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
